// File: rtl/usb4_prbs_pkg.sv
// Shared PRBS11 constants, FSM state type and LFSR step
// function for the Gen4 SLOS transmitter and checker.
package usb4_prbs_pkg;

   localparam logic [10:0] PRBS11_SEED_L0 = 11'h7FF;
   localparam logic [10:0] PRBS11_SEED_L1 = 11'h770;
   localparam int          SLOS_LEN_G4    = 448;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } slos_state_e;

   // x^11 + x^9 + 1, MSB is the emitted bit
   function automatic logic [10:0] prbs11_next(
      input logic [10:0] s
   );
      return {s[9:0], s[10] ^ s[8]};
   endfunction

endpackage

// File: rtl/prbs11_lfsr.sv
// PRBS11 state register with seed load and advance.
// Load wins over advance; reset leaves it at the seed.
module prbs11_lfsr
   import usb4_prbs_pkg::*;
#(
   parameter logic [10:0] SEED = PRBS11_SEED_L0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        adv_i,
   output logic [10:0] state_o
);

   logic [10:0] lfsr_q;
   logic [10:0] lfsr_d;

   // select reload, step or hold
   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED;
      end else if (adv_i) begin
         lfsr_d = prbs11_next(lfsr_q);
      end
   end

   // state register, seeded on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/prbs11_gen_g4.sv
// Gen4 SLOS transmitter: serialises seeded PRBS11 ordered
// sets, counted bursts or continuous until enable drops.
module prbs11_gen_g4
   import usb4_prbs_pkg::*;
#(
   parameter int LANE0_LANE1 = 1,
   parameter int OS_LEN      = SLOS_LEN_G4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] os_count,
   output logic       data_out,
   output logic       data_valid,
   output logic       os_start,
   output logic       os_end,
   output logic       done
);

   localparam logic [10:0] SEED =
      (LANE0_LANE1 != 0) ? PRBS11_SEED_L0
                         : PRBS11_SEED_L1;
   localparam int IW = $clog2(OS_LEN);
   localparam logic [IW-1:0] LAST = IW'(OS_LEN - 1);

   slos_state_e   state_q, state_d;
   logic [IW-1:0] bit_idx_q, bit_idx_d;
   logic [7:0]    rem_q, rem_d;
   logic          dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          start_q, start_d;
   logic          end_q, end_d;
   logic          done_q, done_d;
   logic          lfsr_load;
   logic          lfsr_adv;
   logic          emit;
   logic          is_last;
   logic [10:0]   lfsr;

   prbs11_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load_i  (lfsr_load),
      .adv_i   (lfsr_adv),
      .state_o (lfsr)
   );

   assign is_last = (bit_idx_q == LAST);

   // next state, bit counter, burst count and output bits
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      rem_d     = rem_q;
      dout_d    = 1'b0;
      valid_d   = 1'b0;
      start_d   = 1'b0;
      end_d     = 1'b0;
      done_d    = 1'b0;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      emit      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               emit    = 1'b1;
               rem_d   = os_count;
               state_d = SEND;
            end else begin
               bit_idx_d = '0;
               lfsr_load = 1'b1;
            end
         end
         SEND: begin
            if (enable) begin
               emit = 1'b1;
               if (is_last && rem_q != 8'd0) begin
                  rem_d = rem_q - 8'd1;
                  if (rem_q == 8'd1) begin
                     state_d = DONE;
                  end
               end
            end else begin
               state_d   = IDLE;
               bit_idx_d = '0;
               lfsr_load = 1'b1;
            end
         end
         DONE: begin
            done_d    = enable;
            bit_idx_d = '0;
            lfsr_load = 1'b1;
            if (!enable) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            bit_idx_d = '0;
            lfsr_load = 1'b1;
         end
      endcase
      if (emit) begin
         dout_d  = lfsr[10];
         valid_d = 1'b1;
         start_d = (bit_idx_q == '0);
         end_d   = is_last;
         if (is_last) begin
            lfsr_load = 1'b1;
            bit_idx_d = '0;
         end else begin
            lfsr_adv  = 1'b1;
            bit_idx_d = bit_idx_q + 1'b1;
         end
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         bit_idx_q <= '0;
         rem_q     <= 8'd0;
         dout_q    <= 1'b0;
         valid_q   <= 1'b0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         rem_q     <= rem_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         start_q   <= start_d;
         end_q     <= end_d;
         done_q    <= done_d;
      end
   end

   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign os_start   = start_q;
   assign os_end     = end_q;
   assign done       = done_q;

endmodule

// File: tb/tb_prbs11_gen_g4.sv
// Self-checking bench for prbs11_gen_g4, both lanes side
// by side against a sequence-table reference model.
module tb_prbs11_gen_g4;

   localparam int L = 448;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] os_count;
   logic       d0_out, d0_val, d0_st, d0_end, d0_done;
   logic       d1_out, d1_val, d1_st, d1_end, d1_done;

   always #5 clk = ~clk;

   prbs11_gen_g4 #(.LANE0_LANE1(1)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .os_count   (os_count),
      .data_out   (d0_out),
      .data_valid (d0_val),
      .os_start   (d0_st),
      .os_end     (d0_end),
      .done       (d0_done)
   );

   prbs11_gen_g4 #(.LANE0_LANE1(0)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .os_count   (os_count),
      .data_out   (d1_out),
      .data_valid (d1_val),
      .os_start   (d1_st),
      .os_end     (d1_end),
      .done       (d1_done)
   );

   int tests = 0;
   int fails = 0;
   int printed = 0;

   bit g0 [L];
   bit g1 [L];

   bit m_act, m_done, m_cont;
   int m_idx, m_left;
   bit e_d0, e_d1, e_val, e_st, e_end, e_done;

   int cyc_n, n_valid, n_start, n_end, n_done;
   int first_valid, last_valid, first_start;
   int last_end, first_done;
   bit q0 [$];
   bit q1 [$];

   typedef struct {
      int lane;
      int lo;
      int hi;
      bit val;
   } vec_t;

   vec_t vt [$];

   task automatic chk(input string nm,
                      input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_done = 0; m_cont = 0;
      m_idx = 0; m_left = 0;
      e_d0 = 0; e_d1 = 0; e_val = 0;
      e_st = 0; e_end = 0; e_done = 0;
   endtask

   task automatic emit();
      e_val = 1;
      e_d0  = g0[m_idx];
      e_d1  = g1[m_idx];
      e_st  = (m_idx == 0);
      e_end = (m_idx == L - 1);
      if (m_idx == L - 1) begin
         m_idx = 0;
         if (!m_cont) begin
            m_left--;
            if (m_left == 0) begin
               m_act  = 0;
               m_done = 1;
            end
         end
      end else begin
         m_idx++;
      end
   endtask

   task automatic model_step(input bit en, input int cnt);
      e_d0 = 0; e_d1 = 0; e_val = 0;
      e_st = 0; e_end = 0; e_done = 0;
      if (m_done) begin
         e_done = en;
         if (!en) m_done = 0;
      end else if (!m_act) begin
         if (en) begin
            m_act  = 1;
            m_left = cnt;
            m_cont = (cnt == 0);
            m_idx  = 0;
            emit();
         end
      end else if (!en) begin
         m_act = 0;
         m_idx = 0;
      end else begin
         emit();
      end
   endtask

   task automatic clr();
      cyc_n = 0; n_valid = 0; n_start = 0;
      n_end = 0; n_done = 0;
      first_valid = -1; last_valid = -1;
      first_start = -1; last_end = -1;
      first_done = -1;
      q0.delete();
      q1.delete();
   endtask

   task automatic cyc(input bit en, input logic [7:0] cnt);
      logic [9:0] act, exp;
      enable   = en;
      os_count = cnt;
      @(posedge clk);
      if (!reset) model_reset();
      else model_step(en, int'(cnt));
      #1;
      cyc_n++;
      act = {d0_out, d0_val, d0_st, d0_end, d0_done,
             d1_out, d1_val, d1_st, d1_end, d1_done};
      exp = {e_d0, e_val, e_st, e_end, e_done,
             e_d1, e_val, e_st, e_end, e_done};
      tests++;
      if (act !== exp) begin
         fails++;
         if (printed < 20) begin
            printed++;
            $display("FAIL cycle_outputs t=%0t: got %b expected %b",
                     $time, act, exp);
         end
      end
      if (d0_val) begin
         n_valid++;
         q0.push_back(d0_out);
         q1.push_back(d1_out);
         if (first_valid < 0) first_valid = cyc_n;
         last_valid = cyc_n;
      end
      if (d0_st) begin
         n_start++;
         if (first_start < 0) first_start = cyc_n;
      end
      if (d0_end) begin
         n_end++;
         last_end = cyc_n;
      end
      if (d0_done) begin
         n_done++;
         if (first_done < 0) first_done = cyc_n;
      end
   endtask

   function automatic int gold_mism(input int lane);
      int m = 0;
      for (int i = 0; i < q0.size(); i++) begin
         if (lane == 0 && q0[i] != g0[i % L]) m++;
         if (lane == 1 && q1[i] != g1[i % L]) m++;
      end
      return m;
   endfunction

   initial begin
      logic [10:0] s0, s1;
      bit en_r;
      s0 = 11'h7FF;
      s1 = 11'h770;
      for (int i = 0; i < 11; i++) begin
         g0[i] = s0[10 - i];
         g1[i] = s1[10 - i];
      end
      for (int n = 11; n < L; n++) begin
         g0[n] = g0[n - 11] ^ g0[n - 9];
         g1[n] = g1[n - 11] ^ g1[n - 9];
      end

      vt.push_back('{0, 0, 10, 1'b1});
      vt.push_back('{0, 11, 19, 1'b0});
      vt.push_back('{0, 20, 21, 1'b1});
      vt.push_back('{0, 22, 22, 1'b0});
      vt.push_back('{1, 0, 2, 1'b1});
      vt.push_back('{1, 3, 3, 1'b0});
      vt.push_back('{1, 4, 6, 1'b1});
      vt.push_back('{1, 7, 11, 1'b0});
      vt.push_back('{1, 12, 12, 1'b1});
      vt.push_back('{1, 13, 13, 1'b0});
      vt.push_back('{1, 14, 14, 1'b1});

      model_reset();
      enable   = 1'b0;
      os_count = 8'd0;
      reset    = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("reset_outputs",
          int'({d0_out, d0_val, d0_st, d0_end, d0_done,
                d1_out, d1_val, d1_st, d1_end, d1_done}), 0);
      clr();
      cyc(0, 0);
      cyc(0, 0);
      reset = 1'b1;
      cyc(0, 0);

      // single SLOS, enable held high
      clr();
      for (int i = 0; i < 460; i++) cyc(1, 8'd1);
      chk("a_first_valid", first_valid, 1);
      chk("a_n_valid", n_valid, L);
      chk("a_first_start", first_start, 1);
      chk("a_n_start", n_start, 1);
      chk("a_n_end", n_end, 1);
      chk("a_end_cycle", last_end, L);
      chk("a_first_done", first_done, L + 1);
      chk("a_n_done", n_done, 460 - L);
      foreach (vt[k]) begin
         for (int b = vt[k].lo; b <= vt[k].hi; b++) begin
            if (vt[k].lane == 0)
               chk($sformatf("a_l0_bit%0d", b),
                   int'(q0[b]), int'(vt[k].val));
            else
               chk($sformatf("a_l1_bit%0d", b),
                   int'(q1[b]), int'(vt[k].val));
         end
      end
      cyc(0, 8'd1);
      chk("a_done_clear", int'(d0_done), 0);
      cyc(0, 8'd1);

      // three SLOS back-to-back
      clr();
      for (int i = 0; i < 1350; i++) cyc(1, 8'd3);
      chk("b_n_valid", n_valid, 3 * L);
      chk("b_contiguous", last_valid - first_valid + 1, 3 * L);
      chk("b_n_start", n_start, 3);
      chk("b_n_end", n_end, 3);
      chk("b_gold_l0", gold_mism(0), 0);
      chk("b_gold_l1", gold_mism(1), 0);
      cyc(0, 8'd3);
      cyc(0, 8'd3);

      // continuous mode; os_count changes are ignored
      clr();
      cyc(1, 8'd0);
      for (int i = 1; i < 5000; i++)
         cyc(1, 8'($urandom_range(0, 3)));
      chk("c_n_valid", n_valid, 5000);
      chk("c_n_done", n_done, 0);
      chk("c_gold_l0", gold_mism(0), 0);
      chk("c_gold_l1", gold_mism(1), 0);
      cyc(0, 8'd0);
      cyc(0, 8'd0);

      // abort after bit 200, then restart from bit 0
      clr();
      for (int i = 0; i < 201; i++) cyc(1, 8'd1);
      cyc(0, 8'd1);
      chk("abort_valid", int'(d0_val), 0);
      chk("abort_done", int'(d0_done), 0);
      cyc(0, 8'd1);
      clr();
      for (int i = 0; i < 12; i++) cyc(1, 8'd1);
      chk("restart_first_valid", first_valid, 1);
      chk("restart_start", first_start, 1);
      chk("restart_seed_l0", gold_mism(0), 0);
      chk("restart_seed_l1", gold_mism(1), 0);

      // async reset in the middle of a SLOS
      for (int i = 0; i < 100; i++) cyc(1, 8'd0);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_outputs",
          int'({d0_out, d0_val, d0_st, d0_end, d0_done,
                d1_out, d1_val, d1_st, d1_end, d1_done}), 0);
      model_reset();
      cyc(0, 8'd0);
      cyc(0, 8'd0);
      reset = 1'b1;
      clr();
      for (int i = 0; i < 3; i++) cyc(1, 8'd1);
      chk("rst_first_bit_l0", int'(q0[0]), 1);
      chk("rst_first_bit_l1", int'(q1[0]), 1);
      chk("rst_first_valid", first_valid, 1);
      cyc(0, 8'd0);
      cyc(0, 8'd0);

      // random enable / count traffic
      en_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) en_r = ~en_r;
         cyc(en_r, 8'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
